cm_timing_gen: RTL



---
 rtl/cm_timing_if.sv | 32 +++
 rtl/cm_timing_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cm_timing_if.sv
// Line/frame timing bundle between the timing generator and the pixel source /
// configuration side. The generator owns the master modport.
interface cm_timing_if #(
  parameter int BACKPORCH_WIDTH  = 8,
  parameter int FRONTPORCH_WIDTH = 12,
  parameter int BLANK_WIDTH      = 8,
  parameter int LINE_WIDTH       = 10
);
  logic                        Enable;
  logic [BACKPORCH_WIDTH-1:0]  BackPorch;
  logic [FRONTPORCH_WIDTH-1:0] FrontPorch;
  logic [FRONTPORCH_WIDTH-1:0] LineLength;
  logic [BLANK_WIDTH-1:0]      BlankLength;
  logic [LINE_WIDTH-1:0]       LinesPerFrame;

  logic                        Sync;
  logic                        Pixel_Valid;
  logic [FRONTPORCH_WIDTH-1:0] PixelX;
  logic [LINE_WIDTH-1:0]       Line_Count;
  logic                        Frame_Start;
  logic                        Cfg_Error;

  modport master (
    input  Enable, BackPorch, FrontPorch, LineLength, BlankLength, LinesPerFrame,
    output Sync, Pixel_Valid, PixelX, Line_Count, Frame_Start, Cfg_Error
  );

  modport slave (
    output Enable, BackPorch, FrontPorch, LineLength, BlankLength, LinesPerFrame,
    input  Sync, Pixel_Valid, PixelX, Line_Count, Frame_Start, Cfg_Error
  );
endinterface

// File: rtl/cm_timing_gen.sv
// Transmit-side line/frame timing generator. Produces the Sync line for the
// capture-side pixel counter plus the pixel window, pixel index, line index
// and frame-start marker. Line geometry is latched at the start of each line
// so configuration changes never disturb a line in progress.
module cm_timing_gen #(
  parameter int BACKPORCH_WIDTH  = 8,
  parameter int FRONTPORCH_WIDTH = 12,
  parameter int BLANK_WIDTH      = 8,
  parameter int LINE_WIDTH       = 10
) (
  input  logic        clk,
  input  logic        rst,
  cm_timing_if.master bus
);
  localparam int FW = FRONTPORCH_WIDTH;
  localparam logic [FW:0] ONE_WIDE = 1;

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t                 state;
  logic [BLANK_WIDTH-1:0] blank_cnt;
  logic [FW-1:0]          pos;

  // Geometry captured at line start
  logic [FW-1:0]          bp_q;       // back porch, zero-extended
  logic [FW-1:0]          fp_q;
  logic [FW-1:0]          ll_last_q;  // last Pos of the line
  logic [LINE_WIDTH-1:0]  lpf_last_q; // Line_Count value that wraps to 0

  // Registered outputs
  logic                   sync_q;
  logic                   pv_q;
  logic [FW-1:0]          px_q;
  logic [LINE_WIDTH-1:0]  lc_q;
  logic                   fs_q;
  logic                   err_q;

  // Next-cycle decode
  logic [FW-1:0]          bp_in;
  logic [FW:0]            bp_in_plus1;
  logic                   cfg_bad;
  logic [FW-1:0]          ll_last_in;
  logic                   blank_done;
  logic                   line_done;
  logic [FW-1:0]          pos_inc;
  logic                   pv_inc;
  logic [FW-1:0]          px_inc;
  logic [LINE_WIDTH-1:0]  lc_inc;

  // Decode configuration validity, segment ends and the next pixel window.
  // NOTE: every signal is fully assigned on every pass, so no latch can be inferred.
  always_comb begin
    bp_in       = FW'(bus.BackPorch);
    bp_in_plus1 = {1'b0, bp_in} + ONE_WIDE;
    cfg_bad     = ({1'b0, bus.FrontPorch} <= bp_in_plus1) ||
                  (bus.FrontPorch > bus.LineLength) ||
                  (bus.LinesPerFrame == '0);
    ll_last_in  = (bus.LineLength == '0) ? '0 : bus.LineLength - FW'(1);
    blank_done  = (bus.BlankLength == '0) ||
                  (blank_cnt >= bus.BlankLength - BLANK_WIDTH'(1));
    line_done   = (pos >= ll_last_q);
    pos_inc     = pos + FW'(1);
    pv_inc      = !err_q && (pos_inc > bp_q) && (pos_inc < fp_q);
    px_inc      = pv_inc ? (pos_inc - bp_q - FW'(1)) : '0;
    lc_inc      = (lc_q == lpf_last_q) ? '0 : lc_q + LINE_WIDTH'(1);
  end

  // Line state machine with registered outputs.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      blank_cnt  <= '0;
      pos        <= '0;
      bp_q       <= '0;
      fp_q       <= '0;
      ll_last_q  <= '0;
      lpf_last_q <= '0;
      sync_q     <= 1'b0;
      pv_q       <= 1'b0;
      px_q       <= '0;
      lc_q       <= '0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lc_q <= '0;
          if (bus.Enable) begin
            state     <= BLANK;
            blank_cnt <= '0;
          end
        end

        BLANK: begin
          if (blank_done) begin
            // Latch the line geometry; Pos 0 can never exceed the back
            // porch, so the first Sync cycle never carries a pixel.
            state      <= ACTIVE;
            pos        <= '0;
            bp_q       <= bp_in;
            fp_q       <= bus.FrontPorch;
            ll_last_q  <= ll_last_in;
            lpf_last_q <= bus.LinesPerFrame - LINE_WIDTH'(1);
            err_q      <= cfg_bad;
            sync_q     <= 1'b1;
            pv_q       <= 1'b0;
            px_q       <= '0;
            fs_q       <= (lc_q == '0);
          end else begin
            blank_cnt <= blank_cnt + BLANK_WIDTH'(1);
          end
        end

        ACTIVE: begin
          fs_q <= 1'b0;
          if (line_done) begin
            sync_q    <= 1'b0;
            pv_q      <= 1'b0;
            px_q      <= '0;
            blank_cnt <= '0;
            if (bus.Enable) begin
              state <= BLANK;
              lc_q  <= lc_inc;
            end else begin
              state <= IDLE;
              lc_q  <= '0;
            end
          end else begin
            pos  <= pos_inc;
            pv_q <= pv_inc;
            px_q <= px_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Sync        = sync_q;
  assign bus.Pixel_Valid = pv_q;
  assign bus.PixelX      = px_q;
  assign bus.Line_Count  = lc_q;
  assign bus.Frame_Start = fs_q;
  assign bus.Cfg_Error   = err_q;
endmodule
